csel_pipe_adder: RTL and testbench



---
 rtl/csel_pipe_adder.sv | 128 ++++++++++++
 tb/tb_csel_pipe_adder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one precompute rank builds both
// carry candidates for every block, then one select rank per block resolves the carry.
module csel_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  // One token: both candidate sums/carries per block, the MSB-carry of the
  // top block under each candidate, and the running carry. Once a block is
  // selected its s0/s1 (and c0/c1) slots both hold the chosen value.
  typedef struct packed {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [NBLK-1:0]  c0;
    logic [NBLK-1:0]  c1;
    logic             m0;
    logic             m1;
    logic             rc;
  } tok_t;

  // Handshake: a transfer happens on any edge where valid & ready are both
  // high. in_ready drops only while the output rank holds a result the
  // consumer refuses; then every rank freezes, otherwise all ranks advance.
  logic stall;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Rank 0 is precompute, ranks 1..NBLK select blocks 0..NBLK-1.
  tok_t          tok_q [NBLK+1];
  tok_t          tok_d [NBLK+1];
  logic [NBLK:0] vld_q;
  logic [NBLK:0] vld_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_s0;
  logic [WIDTH-1:0] p_s1;
  logic [NBLK-1:0]  p_c0;
  logic [NBLK-1:0]  p_c1;
  tok_t             pre;

  assign b_eff = in_sub ? ~in_b : in_b;

  for (genvar j = 0; j < NBLK; j++) begin : g_pre
    assign {p_c0[j], p_s0[j*BLOCK +: BLOCK]} =
      {1'b0, in_a[j*BLOCK +: BLOCK]} + {1'b0, b_eff[j*BLOCK +: BLOCK]};
    assign {p_c1[j], p_s1[j*BLOCK +: BLOCK]} =
      {1'b0, in_a[j*BLOCK +: BLOCK]} + {1'b0, b_eff[j*BLOCK +: BLOCK]} +
      {{BLOCK{1'b0}}, 1'b1};
  end

  // Carry into a sum bit is recovered as s ^ a ^ b at that position.
  assign pre = '{
    s0: p_s0,
    s1: p_s1,
    c0: p_c0,
    c1: p_c1,
    m0: p_s0[WIDTH-1] ^ in_a[WIDTH-1] ^ b_eff[WIDTH-1],
    m1: p_s1[WIDTH-1] ^ in_a[WIDTH-1] ^ b_eff[WIDTH-1],
    rc: in_sub | in_cin
  };

  assign tok_d[0] = accept ? pre : '0;
  assign vld_d    = {vld_q[NBLK-1:0], accept};

  for (genvar r = 1; r <= NBLK; r++) begin : g_sel
    localparam int B = r - 1;
    tok_t             prv;
    tok_t             nxt;
    logic             sel;
    logic             cy;
    logic [BLOCK-1:0] blk;

    assign prv = tok_q[r-1];

    always_comb begin
      nxt = prv;
      sel = prv.rc;
      blk = sel ? prv.s1[B*BLOCK +: BLOCK] : prv.s0[B*BLOCK +: BLOCK];
      cy  = sel ? prv.c1[B] : prv.c0[B];
      nxt.s0[B*BLOCK +: BLOCK] = blk;
      nxt.s1[B*BLOCK +: BLOCK] = blk;
      nxt.c0[B] = cy;
      nxt.c1[B] = cy;
      nxt.rc    = cy;
      if (B == NBLK - 1) begin
        nxt.m0 = sel ? prv.m1 : prv.m0;
        nxt.m1 = sel ? prv.m1 : prv.m0;
      end
    end

    assign tok_d[r] = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tok_q <= '{default: '0};
    end else if (!stall) begin
      vld_q <= vld_d;
      tok_q <= tok_d;
    end
  end

  assign out_valid = vld_q[NBLK];
  assign out_sum   = tok_q[NBLK].s0;
  assign out_cout  = tok_q[NBLK].rc;
  assign out_ovf   = tok_q[NBLK].m0 ^ tok_q[NBLK].rc;

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Bench for csel_pipe_adder: directed vector table, latency probes,
// randomised backpressure and mid-flight reset, all checked through one scoreboard.
module tb_csel_pipe_adder;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NBLK  = WIDTH / BLOCK;
  localparam int EW    = WIDTH + 2;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  logic [EW-1:0] exp_q[$];
  int            n_cmp;
  int            n_bad;
  int            n_out;
  bit            rand_ready;

  csel_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: wide add, signed overflow from the operand/result sign rule.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub | cin)};
    ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {full[WIDTH-1:0], full[WIDTH], ovf};
  endfunction

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input logic [EW-1:0] e);
    int waited;
    bit done;
    waited = 0;
    done = 0;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_q.push_back(e);
        done = 1;
      end else if (++waited > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required acceptance", waited);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d results outstanding after %0d cycles, required 0", name, exp_q.size(), c);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string name);
    bit seen;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        check(name, k, NBLK);
        seen = 1;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no out_valid within 20 cycles, required %0d", name, NBLK);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] prev_out;
    logic          stalled_prev;
    logic          exp_rdy;
    stalled_prev = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      exp_rdy = ~(out_valid & ~out_ready);
      check("in_ready", in_ready, exp_rdy);
      if (stalled_prev) begin
        check("stall_hold_data", {out_sum, out_cout, out_ovf}, prev_out);
        check("stall_hold_valid", out_valid, 1'b1);
      end
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got sum 0x%0h with nothing outstanding, required no output", out_sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", out_sum, e[EW-1:2]);
          check("cout", out_cout, e[1]);
          check("ovf", out_ovf, e[0]);
          n_out++;
        end
      end
      stalled_prev = out_valid & ~out_ready & ~rst;
      prev_out = {out_sum, out_cout, out_ovf};
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t          vt[9];
    int            base;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic          rc;
    logic          rs;

    vt[0] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b0};
    vt[1] = '{a:16'h00FF, b:16'h0000, cin:1'b1, sub:1'b0, sum:16'h0100, cout:1'b0, ovf:1'b0};
    vt[2] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h8000, cout:1'b0, ovf:1'b1};
    vt[3] = '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1, sum:16'h7FFF, cout:1'b1, ovf:1'b1};
    vt[4] = '{a:16'h0005, b:16'h0007, cin:1'b1, sub:1'b1, sum:16'hFFFE, cout:1'b0, ovf:1'b0};
    vt[5] = '{a:16'h1234, b:16'h1234, cin:1'b0, sub:1'b1, sum:16'h0000, cout:1'b1, ovf:1'b0};
    vt[6] = '{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b1};
    vt[7] = '{a:16'h1234, b:16'h4321, cin:1'b1, sub:1'b0, sum:16'h5556, cout:1'b0, ovf:1'b0};
    vt[8] = '{a:16'hAAAA, b:16'h5555, cin:1'b1, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b0};

    n_cmp = 0;
    n_bad = 0;
    n_out = 0;
    rand_ready = 0;

    // Reset held two edges with operands offered; they must never emerge.
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 16'hAAAA;
    in_b = 16'h5555;
    in_cin = 1'b1;
    in_sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sum", out_sum, 16'h0000);
      check("rst_out_cout", out_cout, 1'b0);
      check("rst_out_ovf", out_ovf, 1'b0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Directed table, back-to-back at full rate.
    for (int i = 0; i < 9; i++)
      drive(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, {vt[i].sum, vt[i].cout, vt[i].ovf});
    wait_drain("table_drain");

    // Latency from an empty pipeline.
    drive(16'h0001, 16'h0002, 1'b0, 1'b0, {16'h0003, 1'b0, 1'b0});
    measure_latency("latency");
    wait_drain("latency_drain");

    // Random operands under pseudo-random backpressure.
    rand_ready = 1;
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    wait_drain("bp_drain");
    rand_ready = 0;
    check("bp_count", n_out - base, 16);
    @(posedge clk);
    #1;

    // Reset one edge before the first of three in-flight results would emerge.
    drive(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    drive(16'h3333, 16'h0001, 1'b1, 1'b0, model(16'h3333, 16'h0001, 1'b1, 1'b0));
    drive(16'h4000, 16'h0010, 1'b0, 1'b1, model(16'h4000, 16'h0010, 1'b0, 1'b1));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_out_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    drive(16'h1111, 16'h0111, 1'b0, 1'b1, {16'h1000, 1'b1, 1'b0});
    measure_latency("midrst_latency");
    wait_drain("midrst_drain");

    repeat (6) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
